// File: rtl/rca_ft_pkg.sv
// Shared types and helpers for the self-healing ripple-carry adder.
// Holds the test FSM states and the per-cell golden response.
package rca_ft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TEST,
        ST_DONE
    } state_t;

    function automatic int cidx_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Expected {cout,s} of a healthy full adder for pattern {a,b,ci}
    function automatic logic [1:0] golden(input logic [2:0] p);
        return {1'b0, p[0]} + {1'b0, p[1]} + {1'b0, p[2]};
    endfunction

endpackage

// File: rtl/rca_ft_selfheal_fa_cell.sv
// One full-adder cell with a self-test input mux and stuck-at injection.
// Injection acts on the cell outputs whatever the input source.
module fa_cell (
    input  logic       a,
    input  logic       b,
    input  logic       ci,
    input  logic       test_sel,
    input  logic [2:0] test_pat,
    input  logic       inj_s1,
    input  logic       inj_c0,
    output logic       s,
    output logic       co
);
    logic xa, xb, xc;

    assign {xa, xb, xc} = test_sel ? test_pat : {a, b, ci};
    assign s  = (xa ^ xb ^ xc) | inj_s1;
    assign co = ((xa & xb) | (xa & xc) | (xb & xc)) & ~inj_c0;

endmodule

// File: rtl/rca_ft_selfheal.sv
// Fault-tolerant RCA: WIDTH+1 cells, built-in self-test and carry-chain
// repair that skips the lowest faulty cell.
module rca_ft_selfheal
    import rca_ft_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CIDX_W = cidx_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic              in_valid,
    output logic [WIDTH:0]    sum,
    output logic              out_valid,
    input  logic              test_start,
    output logic              test_busy,
    output logic              test_done,
    output logic              fault_found,
    output logic [CIDX_W-1:0] fault_cell,
    output logic              uncorrectable,
    input  logic [WIDTH:0]    inj_sum_sa1,
    input  logic [WIDTH:0]    inj_cout_sa0
);
    localparam logic [CIDX_W-1:0] LAST = CIDX_W'(WIDTH);

    state_t             state;
    logic [CIDX_W-1:0]  tc;
    logic [2:0]         tp;
    logic [WIDTH:0]     scratch;
    logic [WIDTH:0]     scr_nxt;
    logic [WIDTH:0]     cell_s;
    logic [WIDTH:0]     cell_co;
    logic [WIDTH:0]     add_res;
    logic [CIDX_W-1:0]  low;
    logic               map_en;
    logic               in_test;

    assign map_en  = fault_found;
    assign in_test = (state == ST_TEST);

    for (genvar j = 0; j <= WIDTH; j++) begin : g_cell
        logic ca, cb, cc, s, co;
        if (j == 0) begin : g_c0
            assign ca = a[0];
            assign cb = b[0];
            assign cc = cin;
        end else begin : g_cj
            logic sh, skip_prev, na, nb;
            // Cells above the skipped one serve the next lower bit
            assign sh        = map_en && (CIDX_W'(j) > fault_cell);
            assign skip_prev = map_en && (fault_cell == CIDX_W'(j - 1));
            if (j < WIDTH) begin : g_n
                assign na = a[j];
                assign nb = b[j];
            end else begin : g_s
                assign na = 1'b0;
                assign nb = 1'b0;
            end
            assign ca = sh ? a[j-1] : na;
            assign cb = sh ? b[j-1] : nb;
            if (j == 1) begin : g_c1
                assign cc = skip_prev ? cin : g_cell[0].co;
            end else begin : g_cn
                assign cc = skip_prev ? g_cell[j-2].co : g_cell[j-1].co;
            end
        end
        fa_cell u_fa (
            .a        (ca),
            .b        (cb),
            .ci       (cc),
            .test_sel (in_test && (tc == CIDX_W'(j))),
            .test_pat (tp),
            .inj_s1   (inj_sum_sa1[j]),
            .inj_c0   (inj_cout_sa0[j]),
            .s        (s),
            .co       (co)
        );
        assign cell_s[j]  = s;
        assign cell_co[j] = co;
    end

    always_comb begin
        logic [CIDX_W-1:0] idx;
        add_res = '0;
        idx     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = (map_en && CIDX_W'(i) >= fault_cell) ? CIDX_W'(i + 1)
                                                       : CIDX_W'(i);
            add_res[i] = cell_s[idx];
        end
        add_res[WIDTH] = cell_co[idx];
    end

    always_comb begin
        scr_nxt     = scratch;
        scr_nxt[tc] = scratch[tc] | ({cell_co[tc], cell_s[tc]} != golden(tp));
        low         = '0;
        for (int k = WIDTH; k >= 0; k--) begin
            if (scr_nxt[k]) low = CIDX_W'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            tc            <= '0;
            tp            <= '0;
            scratch       <= '0;
            sum           <= '0;
            out_valid     <= 1'b0;
            test_busy     <= 1'b0;
            test_done     <= 1'b0;
            fault_found   <= 1'b0;
            fault_cell    <= '0;
            uncorrectable <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            test_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sum       <= add_res;
                        out_valid <= 1'b1;
                    end
                    if (test_start) begin
                        state     <= ST_TEST;
                        test_busy <= 1'b1;
                        tc        <= '0;
                        tp        <= '0;
                        scratch   <= '0;
                    end
                end
                ST_TEST: begin
                    scratch <= scr_nxt;
                    tp      <= tp + 3'd1;
                    if (tp == 3'd7) begin
                        if (tc == LAST) begin
                            state         <= ST_DONE;
                            test_done     <= 1'b1;
                            fault_found   <= |scr_nxt;
                            fault_cell    <= low;
                            uncorrectable <= $countones(scr_nxt) >= 2;
                        end else begin
                            tc <= tc + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    test_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_ft_selfheal.sv
// Randomised self-checking bench for rca_ft_selfheal (WIDTH=4).
// Reference model works from cell-level fault sets and the repair map rules.
module tb_rca_ft_selfheal;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  a, b;
    logic          cin, in_valid, test_start;
    logic [W:0]    sum;
    logic          out_valid, test_busy, test_done;
    logic          fault_found, uncorrectable;
    logic [CW-1:0] fault_cell;
    logic [W:0]    inj_s, inj_c;

    int checks = 0;
    int errors = 0;

    logic          m_ff;
    logic [CW-1:0] m_fc;
    logic          m_unc;

    rca_ft_selfheal #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a             (a),
        .b             (b),
        .cin           (cin),
        .in_valid      (in_valid),
        .sum           (sum),
        .out_valid     (out_valid),
        .test_start    (test_start),
        .test_busy     (test_busy),
        .test_done     (test_done),
        .fault_found   (fault_found),
        .fault_cell    (fault_cell),
        .uncorrectable (uncorrectable),
        .inj_sum_sa1   (inj_s),
        .inj_cout_sa0  (inj_c)
    );

    always #5 clk = ~clk;

    // Sum produced by walking bits through the cells the map selects
    function automatic logic [W:0] exp_sum(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] r;
        logic c;
        int k;
        r = '0;
        c = ci;
        for (int i = 0; i < W; i++) begin
            k = (m_ff && i >= int'(m_fc)) ? i + 1 : i;
            r[i] = (x[i] ^ y[i] ^ c) | inj_s[k];
            c = (int'(x[i]) + int'(y[i]) + int'(c) >= 2) && !inj_c[k];
        end
        r[W] = c;
        return r;
    endfunction

    function automatic void model_test();
        logic [W:0] bad;
        bad   = inj_s | inj_c;
        m_ff  = |bad;
        m_fc  = '0;
        for (int k = W; k >= 0; k--) if (bad[k]) m_fc = CW'(k);
        m_unc = $countones(bad) >= 2;
    endfunction

    task automatic add_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci);
        @(negedge clk);
        a = x; b = y; cin = ci; in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_test(output int busy_cnt, output int done_at,
                            output int done_cnt);
        @(negedge clk);
        in_valid = 1'b0; test_start = 1'b1;
        @(posedge clk); #1;
        test_start = 1'b0;
        busy_cnt = 0; done_at = 0; done_cnt = 0;
        while (test_busy && busy_cnt < 200) begin
            busy_cnt++;
            if (test_done) begin done_at = busy_cnt; done_cnt++; end
            @(posedge clk); #1;
        end
        model_test();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
        test_start = 1'b0; inj_s = '0; inj_c = '0;
        m_ff = 1'b0; m_fc = '0; m_unc = 1'b0;
        #12;
        checks++;
        if ({sum, out_valid, test_busy, test_done, fault_found, fault_cell,
             uncorrectable} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got sum=%b ov=%b busy=%b done=%b ff=%b fc=%0d unc=%b want all 0",
                     sum, out_valid, test_busy, test_done, fault_found,
                     fault_cell, uncorrectable);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [W-1:0] x, y;
        logic ci;
        add_op(4'b0001, 4'b0010, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || sum !== 5'b00011) begin
            errors++;
            $display("FAIL add_basic got ov=%b sum=%b want ov=1 sum=00011", out_valid, sum);
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0 || sum !== 5'b00011) begin
            errors++;
            $display("FAIL add_pulse got ov=%b sum=%b want ov=0 sum=00011", out_valid, sum);
        end
        for (int n = 0; n < 6; n++) begin
            x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
            add_op(x, y, ci);
            checks++;
            if (out_valid !== 1'b1 || sum !== (W+1)'(x + y + ci)) begin
                errors++;
                $display("FAIL add_rand got ov=%b sum=%b want ov=1 sum=%b",
                         out_valid, sum, (W+1)'(x + y + ci));
            end
            idle_cycle();
        end
    endtask

    task automatic test_selftest();
        int bc, da, dc;
        run_test(bc, da, dc);
        checks++;
        if (bc !== 41 || da !== 41 || dc !== 1) begin
            errors++;
            $display("FAIL selftest_timing got busy=%0d done_at=%0d dones=%0d want 41 41 1", bc, da, dc);
        end
        checks++;
        if (fault_found !== 1'b0 || uncorrectable !== 1'b0 || fault_cell !== '0) begin
            errors++;
            $display("FAIL selftest_clean got ff=%b fc=%0d unc=%b want 0 0 0",
                     fault_found, fault_cell, uncorrectable);
        end
        add_op(4'b1001, 4'b1011, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || sum !== 5'b10100) begin
            errors++;
            $display("FAIL selftest_add got ov=%b sum=%b want ov=1 sum=10100", out_valid, sum);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x, y;
        logic ci;
        for (int n = 0; n < 6; n++) begin
            x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
            add_op(x, y, ci);
            checks++;
            if (out_valid !== 1'b1 || sum !== exp_sum(x, y, ci)) begin
                errors++;
                $display("FAIL b2b got ov=%b sum=%b want ov=1 sum=%b",
                         out_valid, sum, exp_sum(x, y, ci));
            end
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drop got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_sum_fault();
        int bc, da, dc;
        inj_s = 5'b00100; inj_c = '0;
        add_op(4'b0001, 4'b0010, 1'b0);
        checks++;
        if (sum !== 5'b00111 || sum !== exp_sum(4'b0001, 4'b0010, 1'b0)) begin
            errors++;
            $display("FAIL pre_repair got sum=%b want 00111", sum);
        end
        idle_cycle();
        run_test(bc, da, dc);
        checks++;
        if (fault_found !== 1'b1 || fault_cell !== 3'd2 || uncorrectable !== 1'b0 || dc !== 1) begin
            errors++;
            $display("FAIL sum_fault_status got ff=%b fc=%0d unc=%b dones=%0d want 1 2 0 1",
                     fault_found, fault_cell, uncorrectable, dc);
        end
        add_op(4'b0001, 4'b0010, 1'b0);
        checks++;
        if (sum !== 5'b00011) begin
            errors++;
            $display("FAIL repaired_add1 got sum=%b want 00011", sum);
        end
        add_op(4'b1100, 4'b1011, 1'b0);
        checks++;
        if (sum !== 5'b10111) begin
            errors++;
            $display("FAIL repaired_add2 got sum=%b want 10111", sum);
        end
        idle_cycle();
    endtask

    task automatic test_double_fault();
        int bc, da, dc;
        inj_s = '0; inj_c = 5'b01010;
        run_test(bc, da, dc);
        checks++;
        if (fault_found !== 1'b1 || fault_cell !== 3'd1 || uncorrectable !== 1'b1) begin
            errors++;
            $display("FAIL double_fault got ff=%b fc=%0d unc=%b want 1 1 1",
                     fault_found, fault_cell, uncorrectable);
        end
    endtask

    task automatic test_spare();
        int bc, da, dc;
        inj_s = 5'b10000; inj_c = '0;
        run_test(bc, da, dc);
        checks++;
        if (fault_found !== 1'b1 || fault_cell !== 3'd4 || uncorrectable !== 1'b0) begin
            errors++;
            $display("FAIL spare_fault got ff=%b fc=%0d unc=%b want 1 4 0",
                     fault_found, fault_cell, uncorrectable);
        end
        add_op(4'b1000, 4'b0111, 1'b0);
        checks++;
        if (sum !== 5'b01111) begin
            errors++;
            $display("FAIL spare_add got sum=%b want 01111", sum);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        int bc, da, dc, seen;
        logic [W:0] held;
        inj_s = 5'b00100; inj_c = '0;
        run_test(bc, da, dc);
        add_op(4'b0011, 4'b0101, 1'b1);
        idle_cycle();
        held = sum;
        @(negedge clk); test_start = 1'b1;
        @(posedge clk); #1;
        test_start = 1'b0;
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || sum !== held) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL busy_ignore got %0d bad cycles want 0", seen);
        end
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if ({sum, out_valid, test_busy, test_done, fault_found, fault_cell,
             uncorrectable} !== '0) begin
            errors++;
            $display("FAIL mid_reset got sum=%b busy=%b ff=%b fc=%0d want all 0",
                     sum, test_busy, fault_found, fault_cell);
        end
        m_ff = 1'b0; m_fc = '0; m_unc = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (test_done !== 1'b0 || test_busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL aborted_test got %0d busy/done cycles want 0", seen);
        end
        add_op(4'b0001, 4'b0010, 1'b0);
        checks++;
        if (sum !== 5'b00111 || sum !== exp_sum(4'b0001, 4'b0010, 1'b0)) begin
            errors++;
            $display("FAIL map_cleared got sum=%b want 00111", sum);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        int bc, da, dc, mode, k1, k2;
        logic [W-1:0] x, y;
        logic ci;
        for (int it = 0; it < 8; it++) begin
            inj_s = '0; inj_c = '0;
            mode = $urandom_range(0, 3);
            k1 = $urandom_range(0, W);
            k2 = (k1 + 1 + $urandom_range(0, W - 1)) % (W + 1);
            if (mode == 1) inj_s[k1] = 1'b1;
            if (mode == 2) inj_c[k1] = 1'b1;
            if (mode == 3) begin
                if ($urandom_range(0, 1) == 1) inj_s[k1] = 1'b1;
                else inj_c[k1] = 1'b1;
                if ($urandom_range(0, 1) == 1) inj_s[k2] = 1'b1;
                else inj_c[k2] = 1'b1;
            end
            run_test(bc, da, dc);
            checks++;
            if (bc !== 41 || fault_found !== m_ff || fault_cell !== m_fc ||
                uncorrectable !== m_unc) begin
                errors++;
                $display("FAIL rand_test got busy=%0d ff=%b fc=%0d unc=%b want 41 %b %0d %b",
                         bc, fault_found, fault_cell, uncorrectable, m_ff, m_fc, m_unc);
            end
            for (int n = 0; n < 5; n++) begin
                x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
                add_op(x, y, ci);
                checks++;
                if (out_valid !== 1'b1 || sum !== exp_sum(x, y, ci)) begin
                    errors++;
                    $display("FAIL rand_add inj_s=%b inj_c=%b got sum=%b want %b",
                             inj_s, inj_c, sum, exp_sum(x, y, ci));
                end
                if (m_ff && !m_unc) begin
                    checks++;
                    if (sum !== (W+1)'(x + y + ci)) begin
                        errors++;
                        $display("FAIL rand_repaired got sum=%b want %b",
                                 sum, (W+1)'(x + y + ci));
                    end
                end
            end
            idle_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_selftest();
        test_back_to_back();
        test_sum_fault();
        test_back_to_back();
        test_double_fault();
        test_spare();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_ft_selfheal.md
Name: rca_ft_selfheal

Overview:
Parametrised fault-tolerant ripple-carry adder built from WIDTH+1 full-adder cells, one of which is a spare.
An on-chip self-test FSM drives all 8 input patterns through each cell in isolation, locates a faulty cell, and reroutes the carry chain around it.
Normal additions are registered with a valid strobe.
Successor to the manually-selected 4-bit fault-tolerant RCA: generalised width, automatic test and repair, sequential operation.

Parameters:
WIDTH, 4, operand width; cells 0..WIDTH are instantiated, and cell WIDTH is the spare.
CIDX_W, $clog2(WIDTH+1), width of a cell index.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry in
in_valid  in  1  operand strobe
sum  out  WIDTH+1  registered result, carry-out in MSB
out_valid  out  1  one-cycle pulse, sum is valid
test_start  in  1  start self-test (level sampled)
test_busy  out  1  self-test in progress
test_done  out  1  one-cycle pulse at end of test
fault_found  out  1  at least one faulty cell in the last test
fault_cell  out  CIDX_W  lowest faulty cell index
uncorrectable  out  1  two or more faulty cells found
inj_sum_sa1  in  WIDTH+1  verification fault injection: force cell k sum output to 1
inj_cout_sa0  in  WIDTH+1  verification fault injection: force cell k carry output to 0

Behaviour:
- Reset (async, rst_n=0): sum=0, out_valid=0, test_busy=0, test_done=0, fault_found=0, fault_cell=0, uncorrectable=0. FSM=IDLE. Repair map cleared, so cells 0..WIDTH-1 are used and the spare is idle.
- Repair map:
  - If fault_found=0, bit i uses cell i.
  - If fault_found=1, bit i uses cell i when i<fault_cell, else cell i+1.
  - Carry out of the cell used for bit i-1 feeds the cell used for bit i. The skipped cell's outputs are ignored.
  - sum[WIDTH] = carry out of the cell used for bit WIDTH-1.
- Normal mode (FSM=IDLE):
  - in_valid=1 at edge N → sum = a+b+cin (mod 2^(WIDTH+1)) and out_valid=1 at edge N+1. Latency is 1 cycle.
  - out_valid drops the next cycle unless in_valid is held. Back-to-back operation is allowed.
  - in_valid while test_busy=1 is ignored: no out_valid, sum holds.
- FSM states: IDLE, TEST, DONE.
  - IDLE → TEST when test_start=1. Clear cell index c=0, pattern p=0, and the fault scratch vector.
  - TEST, each cycle: drive cell c test inputs {a,b,ci}=p[2:0] through the per-cell test mux, and compare the cell's {cout,s} against golden = popcount(p). On mismatch set scratch[c].
    - p increments 0..7. On p=7, p wraps to 0 and c increments.
    - After c=WIDTH, p=7: go to DONE.
    - Duration is exactly 8*(WIDTH+1) cycles.
  - DONE, one cycle:
    - test_done=1.
    - fault_found = |scratch.
    - fault_cell = lowest set index in scratch, or 0 if none.
    - uncorrectable = popcount(scratch)>=2.
    - Repair map updated. Then → IDLE.
- test_busy=1 in TEST and DONE. test_start is ignored when not in IDLE.
- Fault status and map persist until the next completed test or reset. Reset mid-test aborts the test and clears everything.
- With uncorrectable=1 the map still skips the lowest faulty cell; results are not guaranteed.
- A fault only on the spare (cell WIDTH) sets fault_found=1 and fault_cell=WIDTH. The map then equals the identity mapping, so results stay correct.
- Injection inputs act combinationally on cell outputs in both modes.

Decomposition:
- Package rca_ft_pkg: FSM state enum; golden-response function (popcount of a 3-bit pattern → 2 bits); the cell-index width helper.
- Sub-module fa_cell: one full adder with a test-mode input mux and the two injection inputs. Instantiated WIDTH+1 times by generate.
- Top level: repair-map muxing, carry routing, FSM, scratch vector, result register.

Test Plan:
1. WIDTH=4, no test run, no injection: a=4'b0001, b=4'b0010, cin=0, in_valid one cycle → sum=5'b00011, out_valid=1 for exactly one cycle, one cycle later.
2. test_start pulse, no injection → test_busy high for 41 cycles (40 TEST + DONE), test_done pulse in the last of them, fault_found=0, uncorrectable=0. Then a=4'b1001, b=4'b1011 → sum=5'b10100.
3. inj_sum_sa1=5'b00100:
   - Before test: a=4'b0001, b=4'b0010 → sum=5'b00111 (wrong).
   - After test: fault_found=1, fault_cell=2, uncorrectable=0.
   - Then a=4'b0001, b=4'b0010 → 5'b00011, and a=4'b1100, b=4'b1011 → 5'b10111.
4. inj_cout_sa0=5'b01010 (cells 1 and 3) → test gives fault_found=1, fault_cell=1, uncorrectable=1.
5. inj_sum_sa1=5'b10000 (spare only) → fault_cell=4, fault_found=1. Then a=4'b1000, b=4'b0111 → 5'b01111.
6. Fault map set (scenario 3), new test started, rst_n asserted 10 cycles into TEST → all outputs 0 immediately, map cleared, no test_done pulse. in_valid during test is ignored (no out_valid).
